// File: rtl/bandpower_mc.sv
// rtl/bandpower_mc.sv - multi-channel windowed mean-square power estimator
module bandpower_mc #(
    parameter int DATA_W    = 16,
    parameter int NCH       = 4,
    parameter int WIN_LOG2  = 6,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 14,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int ACC_W    = 2*DATA_W + WIN_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     clr,
    output logic                     power_valid,
    output logic [CH_W-1:0]          power_ch,
    output logic [OUT_W-1:0]         power_out,
    output logic                     power_sat
);

    localparam int SQ_W = 2*DATA_W;

    // Per-channel window state: running sum of squares and samples seen so far
    logic [ACC_W-1:0]    acc [NCH];
    logic [WIN_LOG2-1:0] cnt [NCH];

    logic                ch_ok;
    logic                accept;
    logic [SQ_W-1:0]     x_ext;
    logic [SQ_W-1:0]     sq;
    logic [ACC_W-1:0]    acc_sel;
    logic [WIN_LOG2-1:0] cnt_sel;
    logic [WIN_LOG2-1:0] cnt_nxt;
    logic [ACC_W-1:0]    total;
    logic                is_final;
    logic [ACC_W-1:0]    mean;
    logic                sat;

    // Square the sample, add it to the selected channel's sum and form the result
    always_comb begin
        ch_ok   = 32'(in_ch) < 32'(NCH);
        accept  = in_valid && ch_ok && !clr;
        // Sign-extending to 2*DATA_W and multiplying modulo 2^(2*DATA_W) gives the
        // exact square, including the most-negative input.
        x_ext   = {{DATA_W{x_in[DATA_W-1]}}, x_in};
        sq      = x_ext * x_ext;
        acc_sel = '0;
        cnt_sel = '0;
        if (ch_ok) begin
            acc_sel = acc[in_ch];
            cnt_sel = cnt[in_ch];
        end
        cnt_nxt  = cnt_sel + WIN_LOG2'(1);
        total    = acc_sel + {{WIN_LOG2{1'b0}}, sq};
        is_final = &cnt_sel;
        mean     = total >> (WIN_LOG2 + OUT_SHIFT);
        sat      = |(mean >> OUT_W);
    end

    // Window bookkeeping and registered result presentation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            power_valid <= 1'b0;
            power_ch    <= '0;
            power_out   <= '0;
            power_sat   <= 1'b0;
        end else begin
            power_valid <= 1'b0;
            if (clr) begin
                for (int i = 0; i < NCH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (accept) begin
                if (is_final) begin
                    acc[in_ch]  <= '0;
                    cnt[in_ch]  <= '0;
                    power_valid <= 1'b1;
                    power_ch    <= in_ch;
                    power_out   <= sat ? {OUT_W{1'b1}} : OUT_W'(mean);
                    power_sat   <= sat;
                end else begin
                    acc[in_ch] <= total;
                    cnt[in_ch] <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bandpower_mc.sv
// tb/tb_bandpower_mc.sv - self-checking bench for bandpower_mc
module tb_bandpower_mc;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int WL  = 2;
    localparam int OW  = 16;
    localparam int OS  = 0;
    localparam int WIN = 1 << WL;
    localparam longint OMAX = (64'd1 << OW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ch = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic                 pv;
    logic                 pch;
    logic [OW-1:0]        pout;
    logic                 psat;

    logic                 v3 = 1'b0;
    logic [1:0]           ch3 = 2'd0;
    logic signed [DW-1:0] x3 = '0;
    logic                 pv3;
    logic [1:0]           pch3;
    logic [OW-1:0]        pout3;
    logic                 psat3;

    bandpower_mc #(.DATA_W(DW), .NCH(NCH), .WIN_LOG2(WL), .OUT_W(OW), .OUT_SHIFT(OS)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .x_in(x_in), .clr(clr),
        .power_valid(pv), .power_ch(pch), .power_out(pout), .power_sat(psat)
    );

    // Three-channel instance so an out-of-range index (3) can be presented.
    bandpower_mc #(.DATA_W(DW), .NCH(3), .WIN_LOG2(WL), .OUT_W(OW), .OUT_SHIFT(OS)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ch(ch3), .x_in(x3), .clr(1'b0),
        .power_valid(pv3), .power_ch(pch3), .power_out(pout3), .power_sat(psat3)
    );

    int checks = 0;
    int errors = 0;

    int     q [NCH][$];
    logic   e_valid = 1'b0;
    int     e_ch = 0;
    int     e_out = 0;
    logic   e_sat = 1'b0;
    int     pulses = 0;
    int     last_ch = 0;
    int     last_out = 0;
    logic   last_sat = 1'b0;

    task automatic step(input logic v, input int ch, input int x, input logic c, input logic r);
        longint s;
        @(negedge clk);
        in_valid = v;
        in_ch    = ch[0];
        x_in     = x[DW-1:0];
        clr      = c;
        rst      = r;
        e_valid  = 1'b0;
        if (r) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
            e_ch = 0; e_out = 0; e_sat = 1'b0;
        end else if (c) begin
            for (int i = 0; i < NCH; i++) q[i].delete();
        end else if (v && ch < NCH) begin
            q[ch].push_back(x);
            if (q[ch].size() == WIN) begin
                s = 0;
                foreach (q[ch][k]) s += longint'(q[ch][k]) * longint'(q[ch][k]);
                s = (s / WIN) >>> OS;
                e_valid = 1'b1;
                e_ch    = ch;
                e_sat   = (s > OMAX);
                e_out   = e_sat ? int'(OMAX) : int'(s);
                q[ch].delete();
            end
        end
        @(posedge clk);
        #1;
        if (pv === 1'b1) begin
            pulses++;
            last_ch  = int'(pch);
            last_out = int'(pout);
            last_sat = psat;
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 0, 5, 1'b0, 1'b1);
        checks++;
        if (pv !== 1'b0 || pch !== 1'b0 || pout !== 16'd0 || psat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b ch=%b out=%0d sat=%b want all zero", pv, pch, pout, psat);
        end
    endtask

    task automatic test_basic();
        int p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 0, 100, 1'b0, 1'b0);
            checks++;
            if (pv !== e_valid || pch !== e_ch[0] || pout !== e_out[OW-1:0] || psat !== e_sat) begin
                errors++;
                $display("FAIL basic_cycle%0d got v=%b ch=%b out=%0d sat=%b want v=%b ch=%0d out=%0d sat=%b",
                         i, pv, pch, pout, psat, e_valid, e_ch, e_out, e_sat);
            end
        end
        checks++;
        if (pulses - p0 != 1 || last_ch != 0 || last_out != 10000 || last_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got pulses=%0d ch=%0d out=%0d sat=%b want 1 0 10000 0",
                     pulses - p0, last_ch, last_out, last_sat);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) step(1'b1, 0, -32768, 1'b0, 1'b0);
        checks++;
        if (pv !== 1'b1 || pout !== 16'hFFFF || psat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clip got v=%b out=%0d sat=%b want 1 65535 1", pv, pout, psat);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 0, 1, 1'b0, 1'b0);
        checks++;
        if (pv !== 1'b1 || pout !== 16'd1 || psat !== 1'b0) begin
            errors++;
            $display("FAIL sat_next_window got v=%b out=%0d sat=%b want 1 1 0", pv, pout, psat);
        end
    endtask

    task automatic test_back_to_back();
        int got_ch [2];
        int got_out [2];
        int got_at [2];
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i % 2, (i % 2 == 0) ? 10 : 20, 1'b0, 1'b0);
            checks++;
            if (pv !== e_valid || pch !== e_ch[0] || pout !== e_out[OW-1:0] || psat !== e_sat) begin
                errors++;
                $display("FAIL b2b_cycle%0d got v=%b ch=%b out=%0d want v=%b ch=%0d out=%0d",
                         i, pv, pch, pout, e_valid, e_ch, e_out);
            end
            if (pv === 1'b1 && n < 2) begin
                got_ch[n] = int'(pch); got_out[n] = int'(pout); got_at[n] = i; n++;
            end
        end
        checks++;
        if (n != 2 || got_at[0] != 6 || got_at[1] != 7 || got_ch[0] != 0 || got_out[0] != 100 ||
            got_ch[1] != 1 || got_out[1] != 400) begin
            errors++;
            $display("FAIL b2b_pulses got n=%0d at=%0d,%0d ch=%0d,%0d out=%0d,%0d want 2 at 6,7 ch 0,1 out 100,400",
                     n, got_at[0], got_at[1], got_ch[0], got_ch[1], got_out[0], got_out[1]);
        end
    endtask

    task automatic test_reset_mid_window();
        int p0;
        for (int i = 0; i < 3; i++) step(1'b1, 0, 50, 1'b0, 1'b0);
        step(1'b1, 0, 50, 1'b0, 1'b1);
        checks++;
        if (pv !== 1'b0 || pch !== 1'b0 || pout !== 16'd0 || psat !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_zero got v=%b ch=%b out=%0d sat=%b want all zero", pv, pch, pout, psat);
        end
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(1'b1, 0, 2, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (pulses - p0 != 1 || last_out != 4 || pout !== 16'd4) begin
            errors++;
            $display("FAIL rst_mid_window got pulses=%0d out=%0d want 1 4", pulses - p0, last_out);
        end
    endtask

    task automatic test_clear();
        int p0 = pulses;
        for (int i = 0; i < 3; i++) step(1'b1, 1, 7, 1'b0, 1'b0);
        step(1'b1, 1, 7, 1'b1, 1'b0);
        checks++;
        if (pv !== 1'b0 || pout !== e_out[OW-1:0] || pch !== e_ch[0]) begin
            errors++;
            $display("FAIL clr_hold got v=%b ch=%b out=%0d want 0 %0d %0d", pv, pch, pout, e_ch, e_out);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1, 3, 1'b0, 1'b0);
        checks++;
        if (pulses - p0 != 1 || last_out != 9 || last_ch != 1) begin
            errors++;
            $display("FAIL clr_window got pulses=%0d ch=%0d out=%0d want 1 1 9", pulses - p0, last_ch, last_out);
        end
    endtask

    task automatic test_out_of_range();
        int seq [7] = '{0, 3, 0, 3, 0, 3, 0};
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v3  = (i < 7);
            ch3 = (i < 7) ? seq[i][1:0] : 2'd0;
            x3  = (i < 7 && seq[i] == 3) ? DW'($urandom_range(0, 65535)) : 16'sd100;
            @(posedge clk);
            #1;
            if (pv3 === 1'b1) n++;
            checks++;
            if (pv3 !== (i == 6)) begin
                errors++;
                $display("FAIL oor_pulse_cycle%0d got v=%b want %b", i, pv3, (i == 6));
            end
        end
        v3 = 1'b0;
        checks++;
        if (n != 1 || pch3 !== 2'd0 || pout3 !== 16'd10000 || psat3 !== 1'b0) begin
            errors++;
            $display("FAIL oor_result got pulses=%0d ch=%0d out=%0d sat=%b want 1 0 10000 0", n, pch3, pout3, psat3);
        end
    endtask

    task automatic test_random();
        int x;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: x = -32768;
                1: x = int'($urandom_range(0, 200)) - 100;
                default: x = int'($urandom_range(0, 65535)) - 32768;
            endcase
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, NCH - 1)), x,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0));
            checks++;
            if (pv !== e_valid || pch !== e_ch[0] || pout !== e_out[OW-1:0] || psat !== e_sat) begin
                errors++;
                $display("FAIL random_cycle%0d got v=%b ch=%b out=%0d sat=%b want v=%b ch=%0d out=%0d sat=%b",
                         i, pv, pch, pout, psat, e_valid, e_ch, e_out, e_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_reset_mid_window();
        test_clear();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bandpower_mc.md
BANDPOWER_MC -- requirements
Module: bandpower_mc

Interface
REQ-001 Parameter DATA_W, default 16: signed input sample width.
REQ-002 Parameter NCH, default 4: number of independent channels, at least 1.
REQ-003 Parameter WIN_LOG2, default 6: window length is 2^WIN_LOG2 samples per channel, range 1..12.
REQ-004 Parameter OUT_W, default 16: unsigned output width.
REQ-005 Parameter OUT_SHIFT, default 14: right shift applied to the window mean before saturation.
REQ-006 Localparam CH_W = max(1, clog2(NCH)); localparam ACC_W = 2*DATA_W + WIN_LOG2.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 in_valid  in  1  sample strobe, at most one sample per cycle.
REQ-010 in_ch  in  CH_W  channel index of the current sample.
REQ-011 x_in  in  DATA_W  signed sample.
REQ-012 clr  in  1  synchronous clear of all channel windows, without resetting outputs.
REQ-013 power_valid  out  1  one-cycle pulse when a window result is presented.
REQ-014 power_ch  out  CH_W  channel of the presented result.
REQ-015 power_out  out  OUT_W  unsigned mean-square result.
REQ-016 power_sat  out  1  high with power_valid when the result was clipped.

Function
REQ-017 Per channel, the block SHALL hold an unsigned ACC_W accumulator and a WIN_LOG2-bit sample counter in storage indexed by in_ch.
REQ-018 A sample is accepted when in_valid=1, in_ch<NCH, clr=0 and rst=0.
- Samples with in_ch>=NCH SHALL be ignored, with no state change.
REQ-019 On acceptance: sq = x_in*x_in, unsigned, 2*DATA_W bits.
- -2^(DATA_W-1) squared SHALL be exact.
REQ-020 Non-final sample (count < 2^WIN_LOG2-1): acc += sq; count += 1.
REQ-021 Final sample (count = 2^WIN_LOG2-1): total = acc+sq; acc <= 0; count <= 0.
- The window SHALL contain exactly 2^WIN_LOG2 samples, including the final one.
- No sample is dropped between windows.
REQ-022 Result on final sample: m = (total >> WIN_LOG2) >> OUT_SHIFT.
- If m > 2^OUT_W-1, power_out SHALL be 2^OUT_W-1 and power_sat 1.
- Otherwise power_out = m and power_sat 0.
REQ-023 Latency: power_valid, power_ch, power_out and power_sat SHALL be registered and appear on the cycle after the final-sample edge.
- power_valid SHALL be high for exactly one cycle.
REQ-024 power_out, power_ch and power_sat SHALL hold their last values while power_valid=0.
REQ-025 Channels SHALL be fully independent. Arbitrary interleaving SHALL NOT affect any other channel's accumulation.
REQ-026 Back-to-back final samples on different channels in consecutive cycles SHALL produce consecutive power_valid pulses, with no loss.
REQ-027 The accumulator SHALL never wrap. ACC_W is sufficient by construction.
REQ-028 clr=1 SHALL zero every acc and count on that edge and discard any in_valid sample that cycle.
- clr SHALL NOT suppress a power_valid already scheduled from the previous cycle.
- clr SHALL NOT alter the held output values.

Reset
REQ-029 While rst=1, on each edge:
- All acc and count SHALL be 0.
- power_valid=0, power_out=0, power_ch=0 and power_sat=0.
- Inputs are ignored.
REQ-030 Reset mid-window SHALL discard partial windows.
- The first accepted sample after reset SHALL start a new window.
- No pulse SHALL appear from the pending result.

Verification
(Bench parameters: NCH=2, WIN_LOG2=2, OUT_SHIFT=0, OUT_W=16, DATA_W=16.)
REQ-031 ch0 x=100 for 4 consecutive valid cycles -> one power_valid pulse, one cycle after the 4th sample.
- power_ch=0, power_out=10000, power_sat=0.
REQ-032 ch0 x=-32768 for 4 samples -> power_out=65535, power_sat=1.
- The next window on ch0 (x=1 ×4) -> power_out=1, power_sat=0.
REQ-033 Alternate ch0 x=10 and ch1 x=20, 8 cycles -> pulses on consecutive cycles.
- First pulse: power_ch=0, power_out=100.
- Second pulse: power_ch=1, power_out=400.
REQ-034 ch0 3 samples x=50, then rst for 1 cycle, then ch0 4 samples x=2 -> exactly one pulse, power_out=4.
- Outputs SHALL read 0 after reset.
REQ-035 ch1 3 samples x=7, then clr with in_valid on ch1, then ch1 4 samples x=3 -> one pulse, power_out=9.
REQ-036 in_ch=3 (>=NCH) valid samples interleaved into REQ-031 -> results identical to REQ-031, with no extra pulses.
